regfile_wb_arbiter: RTL and testbench

Write-port arbiter and sequencer for the register file's single write port. Two write-back sources share the port through valid/ready handshakes: the in-order pipeline WB stage (primary) and the long-latency unit return path (secondary, e.g. load/multiply). The block registers the granted write and drives `RegWrite`/`WriteAddress`/`WriteData` of the register file one cycle later. Writes to x0 are consumed but never issued.

---
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the register file: primary WB stage vs long-latency return path.
// Define RF_ARB_STARVE_EN to bound secondary starvation with a wait counter and forced grant.
module regfile_wb_arbiter #(
  parameter int unsigned REG_WIDTH          = 32,
  parameter int unsigned ADDRESS_PORT_WIDTH = 5,
  parameter int unsigned MAX_WAIT           = 4
) (
  input  logic                          CLK,
  input  logic                          ResetN,
  input  logic                          PrimValid,
  output logic                          PrimReady,
  input  logic [ADDRESS_PORT_WIDTH-1:0] PrimAddr,
  input  logic [REG_WIDTH-1:0]          PrimData,
  input  logic                          SecValid,
  output logic                          SecReady,
  input  logic [ADDRESS_PORT_WIDTH-1:0] SecAddr,
  input  logic [REG_WIDTH-1:0]          SecData,
  output logic                          RegWrite,
  output logic [ADDRESS_PORT_WIDTH-1:0] WriteAddress,
  output logic [REG_WIDTH-1:0]          WriteData,
  output logic                          WbSrc
);

  logic override;
  logic prim_grant;
  logic sec_grant;

  logic                          reg_write_q, reg_write_d;
  logic [ADDRESS_PORT_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [REG_WIDTH-1:0]          write_data_q, write_data_d;
  logic                          wb_src_q, wb_src_d;

  // Readies depend only on the valids and the wait counter, never on a downstream stall.
  assign PrimReady  = ~override;
  assign SecReady   = override | ~PrimValid;
  assign prim_grant = PrimValid & PrimReady;
  assign sec_grant  = SecValid & SecReady;

`ifdef RF_ARB_STARVE_EN
  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_WAIT);

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  assign override = SecValid & (wait_cnt_q == CntMax);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!SecValid || sec_grant) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CntMax) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  // Strict primary priority: the secondary may starve.
  assign override = 1'b0;

  logic unused_max_wait;
  assign unused_max_wait = ^MAX_WAIT;
`endif

  // Address and data hold their last value when nothing is granted.
  always_comb begin
    reg_write_d  = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    wb_src_d     = wb_src_q;
    if (prim_grant) begin
      reg_write_d  = (PrimAddr != '0);
      write_addr_d = PrimAddr;
      write_data_d = PrimData;
      wb_src_d     = 1'b0;
    end else if (sec_grant) begin
      reg_write_d  = (SecAddr != '0);
      write_addr_d = SecAddr;
      write_data_d = SecData;
      wb_src_d     = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      wb_src_q     <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      wb_src_q     <= wb_src_d;
    end
  end

  assign RegWrite     = reg_write_q;
  assign WriteAddress = write_addr_q;
  assign WriteData    = write_data_q;
  assign WbSrc        = wb_src_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized bench for regfile_wb_arbiter against a cycle-level reference model.
// The model follows RF_ARB_STARVE_EN the same way the design does.
module tb_regfile_wb_arbiter;

  localparam int unsigned MaxWait = 4;
`ifdef RF_ARB_STARVE_EN
  localparam bit Starve = 1'b1;
`else
  localparam bit Starve = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        ResetN = 1'b1;
  logic        PrimValid = 1'b0;
  logic        PrimReady;
  logic [4:0]  PrimAddr = '0;
  logic [31:0] PrimData = '0;
  logic        SecValid = 1'b0;
  logic        SecReady;
  logic [4:0]  SecAddr = '0;
  logic [31:0] SecData = '0;
  logic        RegWrite;
  logic [4:0]  WriteAddress;
  logic [31:0] WriteData;
  logic        WbSrc;

  regfile_wb_arbiter #(
    .REG_WIDTH         (32),
    .ADDRESS_PORT_WIDTH(5),
    .MAX_WAIT          (MaxWait)
  ) dut (
    .CLK         (CLK),
    .ResetN      (ResetN),
    .PrimValid   (PrimValid),
    .PrimReady   (PrimReady),
    .PrimAddr    (PrimAddr),
    .PrimData    (PrimData),
    .SecValid    (SecValid),
    .SecReady    (SecReady),
    .SecAddr     (SecAddr),
    .SecData     (SecData),
    .RegWrite    (RegWrite),
    .WriteAddress(WriteAddress),
    .WriteData   (WriteData),
    .WbSrc       (WbSrc)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference state: age of the pending secondary in refused cycles, and the expected
  // contents of the write port register.
  int          m_age = 0;
  logic        e_rw = 1'b0;
  logic [4:0]  e_addr = '0;
  logic [31:0] e_data = '0;
  logic        e_src = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_age  = 0;
    e_rw   = 1'b0;
    e_addr = '0;
    e_data = '0;
    e_src  = 1'b0;
  endtask

  // Called at posedge+1; drives one cycle, checks readies mid-cycle and outputs after the edge.
  task automatic cycle(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic sv, input logic [4:0] sa, input logic [31:0] sd,
                       output logic pr, output logic sr);
    logic forced, e_pr, e_sr, pg, sg;
    PrimValid = pv; PrimAddr = pa; PrimData = pd;
    SecValid  = sv; SecAddr  = sa; SecData  = sd;
    #2;
    forced = Starve && sv && (m_age >= int'(MaxWait));
    e_pr   = !forced;
    e_sr   = forced || !pv;
    chk("prim_ready", {31'b0, PrimReady}, {31'b0, e_pr});
    chk("sec_ready", {31'b0, SecReady}, {31'b0, e_sr});
    pr = PrimReady;
    sr = SecReady;
    pg = pv && e_pr;
    sg = sv && e_sr;
    @(posedge CLK);
    #1;
    if (pg) begin
      e_rw = (pa != 5'd0); e_addr = pa; e_data = pd; e_src = 1'b0;
    end else if (sg) begin
      e_rw = (sa != 5'd0); e_addr = sa; e_data = sd; e_src = 1'b1;
    end else begin
      e_rw = 1'b0;
    end
    if (sv && !sg) m_age = (m_age < int'(MaxWait)) ? m_age + 1 : int'(MaxWait);
    else m_age = 0;
    chk("reg_write", {31'b0, RegWrite}, {31'b0, e_rw});
    chk("write_addr", {27'b0, WriteAddress}, {27'b0, e_addr});
    chk("write_data", WriteData, e_data);
    chk("wb_src", {31'b0, WbSrc}, {31'b0, e_src});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic pr, sr;
    logic ppend, spend;
    logic [4:0] pa, sa;
    logic [31:0] pd, sd;
    int first_hi;

    // Reset with both sources requesting: outputs cleared without any clock edge.
    PrimValid = 1'b1; PrimAddr = 5'd17; PrimData = 32'h1111_2222;
    SecValid  = 1'b1; SecAddr  = 5'd18; SecData  = 32'h3333_4444;
    #1 ResetN = 1'b0;
    #2;
    chk("rst_reg_write", {31'b0, RegWrite}, 32'd0);
    chk("rst_write_addr", {27'b0, WriteAddress}, 32'd0);
    chk("rst_write_data", WriteData, 32'd0);
    chk("rst_wb_src", {31'b0, WbSrc}, 32'd0);
    chk("rst_prim_ready", {31'b0, PrimReady}, 32'd1);
    @(posedge CLK);
    #1;
    ResetN = 1'b1;
    model_reset();

    // Single primary write, then an idle cycle.
    cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, pr, sr);
    chk("single_rw", {31'b0, RegWrite}, 32'd1);
    chk("single_addr", {27'b0, WriteAddress}, 32'd5);
    chk("single_data", WriteData, 32'hDEAD_BEEF);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, pr, sr);
    chk("single_rw_off", {31'b0, RegWrite}, 32'd0);

    // Secondary to x0: accepted, never issued.
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, pr, sr);
    chk("x0_ready", {31'b0, sr}, 32'd1);
    chk("x0_rw", {31'b0, RegWrite}, 32'd0);

    // Contention: primary first, secondary as soon as primary leaves.
    cycle(1'b1, 5'd3, 32'h0303_0303, 1'b1, 5'd7, 32'h0707_0707, pr, sr);
    chk("cont_first_addr", {27'b0, WriteAddress}, 32'd3);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h0707_0707, pr, sr);
    chk("cont_second_addr", {27'b0, WriteAddress}, 32'd7);
    chk("cont_second_src", {31'b0, WbSrc}, 32'd1);

    // Starvation: primary valid every cycle, secondary to x9.
    first_hi = -1;
    spend = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 5'(20 + i), 32'(i), spend, 5'd9, 32'hA5A5_A5A5, pr, sr);
      if (spend && sr) begin
        first_hi = i;
        spend = 1'b0;
        chk("starve_prim_refused", {31'b0, pr}, 32'd0);
        chk("starve_addr", {27'b0, WriteAddress}, 32'd9);
        chk("starve_src", {31'b0, WbSrc}, 32'd1);
      end
    end
    chk("starve_grant_cycle", 32'(first_hi), Starve ? 32'(MaxWait) : 32'hFFFF_FFFF);
    cycle(1'b0, 5'd0, 32'h0, spend, 5'd9, 32'hA5A5_A5A5, pr, sr);

    // Reset mid-write with a partially aged secondary pending.
    cycle(1'b1, 5'd11, 32'h0B0B_0B0B, 1'b1, 5'd9, 32'h5555_5555, pr, sr);
    cycle(1'b1, 5'd12, 32'h0C0C_0C0C, 1'b1, 5'd9, 32'h5555_5555, pr, sr);
    chk("pre_rst_rw", {31'b0, RegWrite}, 32'd1);
    #1 ResetN = 1'b0;
    #1;
    chk("mid_rst_rw", {31'b0, RegWrite}, 32'd0);
    chk("mid_rst_addr", {27'b0, WriteAddress}, 32'd0);
    chk("mid_rst_data", WriteData, 32'd0);
    chk("mid_rst_prim_ready", {31'b0, PrimReady}, 32'd1);
    chk("mid_rst_sec_ready", {31'b0, SecReady}, 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    ResetN = 1'b1;
    chk("post_rst_rw", {31'b0, RegWrite}, 32'd0);
    spend = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 5'(14 + i), 32'(100 + i), spend, 5'd9, 32'h5555_5555, pr, sr);
      if (spend && sr) spend = 1'b0;
    end
    cycle(1'b0, 5'd0, 32'h0, spend, 5'd9, 32'h5555_5555, pr, sr);

    // Randomized traffic honouring hold-until-handshake on both sources.
    ppend = 1'b0; spend = 1'b0;
    pa = '0; sa = '0; pd = '0; sd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!ppend && $urandom_range(0, 3) != 0) begin
        ppend = 1'b1; pa = 5'($urandom_range(0, 31)); pd = $urandom;
      end
      if (!spend && $urandom_range(0, 1) != 0) begin
        spend = 1'b1; sa = 5'($urandom_range(0, 31)); sd = $urandom;
      end
      cycle(ppend, pa, pd, spend, sa, sd, pr, sr);
      if (ppend && pr) ppend = 1'b0;
      if (spend && sr) spend = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
